hpdcache_burst_rrarb: RTL and testbench

Round-robin arbiter that shares a single downstream channel (e.g. memory-request or refill-write port) among N requesters issuing multi-beat transfers. Once a requester wins and its first beat is accepted, the grant is locked to it until its last beat is accepted. The grant is also held across downstream back-pressure. Sits between the cache's internal request sources and a shared NoC/memory interface.

---
 rtl/hpdcache_burst_rrarb_if.sv | 35 +++
 rtl/hpdcache_burst_rrarb.sv | 127 ++++++++++++
 tb/tb_hpdcache_burst_rrarb.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hpdcache_burst_rrarb_if.sv
// rtl/hpdcache_burst_rrarb_if.sv - handshake bundle between burst requesters and the shared-channel arbiter
//
// Purpose: groups the per-requester beat handshake and the grant outputs.
// Signals (names seen from the arbiter side):
//   req_i       [N]   per-requester beat valid
//   last_i      [N]   per-requester last-beat flag
//   ready_i           downstream accepts the current beat
//   gnt_o       [N]   one-hot or zero grant vector
//   gnt_idx_o   [IW]  binary index of the granted requester
//   gnt_valid_o       granted requester presents a beat
//   busy_o            a grant is held across cycles
// Modports: slave = arbiter, master = requester/downstream side.
interface hpdcache_burst_rrarb_if #(
   parameter int N = 4
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]  req_i;
   logic [N-1:0]  last_i;
   logic          ready_i;
   logic [N-1:0]  gnt_o;
   logic [IW-1:0] gnt_idx_o;
   logic          gnt_valid_o;
   logic          busy_o;

   modport slave (
      input  req_i, last_i, ready_i,
      output gnt_o, gnt_idx_o, gnt_valid_o, busy_o
   );

   modport master (
      output req_i, last_i, ready_i,
      input  gnt_o, gnt_idx_o, gnt_valid_o, busy_o
   );
endinterface

// File: rtl/hpdcache_burst_rrarb.sv
// rtl/hpdcache_burst_rrarb.sv - round-robin arbiter with burst locking for a shared downstream channel
//
// Purpose: grants one of N requesters per transfer; the grant is held across
// back-pressure (HOLD) and locked across multi-beat bursts (LOCK) until the
// owner's last beat is accepted.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    hpdcache_burst_rrarb_if.slave (req/last/ready in, grant outputs out)
module hpdcache_burst_rrarb #(
   parameter int N = 4
) (
   input logic                   clk_i,
   input logic                   rst_i,
   hpdcache_burst_rrarb_if.slave bus
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      LOCK = 2'd2
   } state_t;

   state_t        state_q;
   logic [IW-1:0] ptr_q;
   logic [IW-1:0] owner_q;

   logic          pick_found;
   logic [IW-1:0] pick_idx;
   logic [IW:0]   cand;

   logic [N-1:0]  gnt;
   logic [IW-1:0] gnt_idx;
   logic          gnt_valid;
   logic          busy;
   logic [IW-1:0] cur_idx;
   logic          accept;
   logic          cur_last;

   function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] x);
      return (x == IW'(N - 1)) ? '0 : x + 1'b1;
   endfunction

   // Round-robin search starting at ptr_q. The candidate sum stays below 2N,
   // so a single conditional subtract implements the modulo-N wrap.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, ptr_q} + (IW + 1)'(k);
         if (cand >= (IW + 1)'(N)) begin
            cand = cand - (IW + 1)'(N);
         end
         if (!pick_found && bus.req_i[cand[IW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      busy      = 1'b0;
      if (!rst_i) begin
         if (state_q == IDLE) begin
            if (pick_found) begin
               gnt     = {{(N-1){1'b0}}, 1'b1} << pick_idx;
               gnt_idx = pick_idx;
            end
            gnt_valid = |bus.req_i;
         end else begin
            gnt       = {{(N-1){1'b0}}, 1'b1} << owner_q;
            gnt_idx   = owner_q;
            gnt_valid = bus.req_i[owner_q];
            busy      = 1'b1;
         end
      end
   end

   assign cur_idx  = (state_q == IDLE) ? pick_idx : owner_q;
   assign accept   = gnt_valid & bus.ready_i;
   assign cur_last = bus.last_i[cur_idx];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept && cur_last) begin
                  ptr_q <= inc_idx(pick_idx);
               end else if (accept) begin
                  state_q <= LOCK;
                  owner_q <= pick_idx;
               end else if (pick_found) begin
                  // Request present but stalled: freeze this winner so the
                  // grant cannot move while the downstream is not ready.
                  state_q <= HOLD;
                  owner_q <= pick_idx;
               end
            end
            HOLD, LOCK: begin
               if (accept && cur_last) begin
                  state_q <= IDLE;
                  ptr_q   <= inc_idx(owner_q);
               end else if (accept) begin
                  state_q <= LOCK;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt_o       = gnt;
   assign bus.gnt_idx_o   = gnt_idx;
   assign bus.gnt_valid_o = gnt_valid;
   assign bus.busy_o      = busy;
endmodule

// File: tb/tb_hpdcache_burst_rrarb.sv
// tb/tb_hpdcache_burst_rrarb.sv - self-checking bench for hpdcache_burst_rrarb
module tb_hpdcache_burst_rrarb;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   // Reference model: a transfer either has an owner (held) or not.
   bit   m_held  = 1'b0;
   int   m_owner = 0;
   int   m_ptr   = 0;

   logic [N-1:0] exp_gnt;
   logic [1:0]   exp_idx;
   logic         exp_valid;
   logic         exp_busy;

   hpdcache_burst_rrarb_if #(.N(N)) bus ();

   hpdcache_burst_rrarb #(.N(N)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic int rr_winner(input logic [N-1:0] r, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   // Drive one cycle of inputs, check the outputs, then advance the model
   // across the rising edge.
   task automatic step(input logic [N-1:0] r, input logic [N-1:0] l,
                       input logic rdy, input logic rs);
      int w;
      bit acc;
      rst         = rs;
      bus.req_i   = r;
      bus.last_i  = l;
      bus.ready_i = rdy;
      #2;
      w = m_held ? m_owner : rr_winner(r, m_ptr);
      if (rs) begin
         exp_gnt = '0; exp_idx = '0; exp_valid = 1'b0; exp_busy = 1'b0;
      end else if (m_held) begin
         exp_gnt = N'(1) << m_owner; exp_idx = 2'(m_owner);
         exp_valid = r[m_owner]; exp_busy = 1'b1;
      end else begin
         exp_gnt = (w < 0) ? '0 : N'(1) << w;
         exp_idx = (w < 0) ? 2'd0 : 2'(w);
         exp_valid = |r; exp_busy = 1'b0;
      end
      checks++;
      assert (bus.gnt_o === exp_gnt) else begin
         errors++; $error("FAIL gnt_o obs=%b exp=%b t=%0t", bus.gnt_o, exp_gnt, $time);
      end
      checks++;
      assert (bus.gnt_idx_o === exp_idx) else begin
         errors++; $error("FAIL gnt_idx_o obs=%0d exp=%0d t=%0t", bus.gnt_idx_o, exp_idx, $time);
      end
      checks++;
      assert (bus.gnt_valid_o === exp_valid) else begin
         errors++; $error("FAIL gnt_valid_o obs=%b exp=%b t=%0t", bus.gnt_valid_o, exp_valid, $time);
      end
      checks++;
      assert (bus.busy_o === exp_busy) else begin
         errors++; $error("FAIL busy_o obs=%b exp=%b t=%0t", bus.busy_o, exp_busy, $time);
      end
      @(posedge clk);
      if (rs) begin
         m_held = 1'b0; m_owner = 0; m_ptr = 0;
      end else begin
         acc = exp_valid && rdy;
         if (acc && l[w]) begin
            m_held = 1'b0; m_ptr = (w + 1) % N;
         end else if (acc || (!m_held && w >= 0)) begin
            m_held = 1'b1; m_owner = w;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      bus.req_i = '0; bus.last_i = '0; bus.ready_i = 1'b0;
      @(negedge clk);
      // Reset with live requests must still show idle outputs.
      step(4'b1111, 4'b1111, 1'b1, 1'b1);
      step(4'b0000, 4'b0000, 1'b0, 1'b1);

      // Alternating single-beat transfers: 1,3,1,3.
      repeat (4) step(4'b1010, 4'b1111, 1'b1, 1'b0);

      // Back-pressure hold for 3 cycles, then accept; next grant goes to 2.
      repeat (3) step(4'b0110, 4'b1111, 1'b0, 1'b0);
      step(4'b0110, 4'b1111, 1'b1, 1'b0);
      step(4'b0110, 4'b1111, 1'b1, 1'b0);

      // Requester 0 four-beat burst with requester 3 competing.
      step(4'b0000, 4'b0000, 1'b1, 1'b0);
      step(4'b0000, 4'b0000, 1'b1, 1'b1);
      repeat (3) step(4'b1001, 4'b0000, 1'b1, 1'b0);
      step(4'b1001, 4'b0001, 1'b1, 1'b0);
      step(4'b1000, 4'b1000, 1'b1, 1'b0);

      // Wrap-around: owner 3 just finished, so 4'b1001 grants 0.
      step(4'b1001, 4'b1111, 1'b1, 1'b0);

      // Lock on 2, owner drops its request for 2 cycles mid-burst.
      step(4'b0100, 4'b0000, 1'b1, 1'b0);
      repeat (2) step(4'b1011, 4'b0000, 1'b1, 1'b0);
      step(4'b0100, 4'b0000, 1'b1, 1'b0);
      step(4'b1111, 4'b0100, 1'b1, 1'b0);

      // Reset in the middle of a burst, then 4'b1111 grants 0.
      step(4'b0010, 4'b0000, 1'b1, 1'b0);
      step(4'b0010, 4'b0000, 1'b1, 1'b0);
      repeat (2) step(4'b1111, 4'b0000, 1'b1, 1'b1);
      step(4'b1111, 4'b1111, 1'b1, 1'b0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic [N-1:0] r, l;
         r = N'($urandom);
         l = N'($urandom) & N'($urandom);
         step(r, l, ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
